// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the demux_seq serializer.
// Optional zero-skipping is selected with the DEMUX_SEQ_SKIP_ZERO_EN macro in demux_seq.sv.
package demux_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef logic [1:0] chan_t;

    localparam int HOLD_W = 4;

    // Channel k maps straight onto {s0,s1} = k.
    function automatic logic [1:0] chan_sel(input chan_t ch);
        return ch;
    endfunction

    // Lowest set bit of mask at or above start; result is {found, index}.
    function automatic logic [2:0] first_set_from(input logic [3:0] mask, input logic [2:0] start);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/demux_seq_hold_ctr.sv
// Loadable down-counter with zero flag, used to time each channel hold.
module demux_seq_hold_ctr
    import demux_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              dec,
    input  logic [HOLD_W-1:0] load_val,
    output logic              zero
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/demux_seq.sv
// Serializes a 4-bit word onto d/{s0,s1} of a 1-to-4 demux, one channel per HOLD_CYCLES.
// Define DEMUX_SEQ_SKIP_ZERO_EN to skip channels whose latched bit is 0.
//   state    | meaning
//   ST_IDLE  | waiting for in_valid, in_ready high
//   ST_DRIVE | driving channel chan_q for HOLD_CYCLES cycles
//   ST_DONE  | one-cycle done pulse, then back to idle
module demux_seq
    import demux_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       d,
    output logic       s0,
    output logic       s1,
    output logic       dv,
    output logic       busy,
    output logic       done
);

    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    chan_t      chan_q, chan_d;
    logic [3:0] word_q, word_d;

    logic       in_ready_q, in_ready_d;
    logic       busy_q, busy_d;
    logic       dv_q, dv_d;
    logic       d_q, d_d;
    logic       s0_q, s0_d;
    logic       s1_q, s1_d;
    logic       done_q, done_d;

    logic       ctr_load;
    logic       ctr_dec;
    logic       ctr_zero;
    logic [3:0] acc_mask;
    logic [3:0] run_mask;
    logic [2:0] nxt;
    logic [1:0] sel;

    demux_seq_hold_ctr u_hold_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load),
        .dec      (ctr_dec),
        .load_val (HOLD_LD),
        .zero     (ctr_zero)
    );

`ifdef DEMUX_SEQ_SKIP_ZERO_EN
    assign acc_mask = in_data;
    assign run_mask = word_q;
`else
    assign acc_mask = 4'hF;
    assign run_mask = 4'hF;
`endif

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        word_d   = word_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        nxt      = 3'b000;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    word_d = in_data;
                    nxt    = first_set_from(acc_mask, 3'd0);
                    if (nxt[2]) begin
                        state_d  = ST_DRIVE;
                        chan_d   = nxt[1:0];
                        ctr_load = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRIVE: begin
                if (ctr_zero) begin
                    nxt = first_set_from(run_mask, {1'b0, chan_q} + 3'd1);
                    if (nxt[2]) begin
                        chan_d   = nxt[1:0];
                        ctr_load = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        chan_d  = '0;
                    end
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                chan_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                chan_d  = '0;
            end
        endcase

        // Outputs decode the next state so they are registered alongside it.
        sel        = chan_sel(chan_d);
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        dv_d       = (state_d == ST_DRIVE);
        done_d     = (state_d == ST_DONE);
        d_d        = (state_d == ST_DRIVE) ? word_d[chan_d] : 1'b0;
        s0_d       = (state_d == ST_DRIVE) ? sel[1] : 1'b0;
        s1_d       = (state_d == ST_DRIVE) ? sel[0] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            chan_q     <= '0;
            word_q     <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            dv_q       <= 1'b0;
            d_q        <= 1'b0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            word_q     <= word_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            dv_q       <= dv_d;
            d_q        <= d_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            done_q     <= done_d;
        end
    end

    // in_ready is held low while reset is asserted even though its flop resets high.
    assign in_ready = in_ready_q & rst_n;
    assign busy     = busy_q;
    assign dv       = dv_q;
    assign d        = d_q;
    assign s0       = s0_q;
    assign s1       = s1_q;
    assign done     = done_q;

endmodule

// File: tb/tb_demux_seq.sv
// Directed bench for demux_seq with HOLD_CYCLES=1 and HOLD_CYCLES=3 instances.
module tb_demux_seq;

    logic clk;
    logic rst_n;

    logic       in_valid_1, in_ready_1, d_1, s0_1, s1_1, dv_1, busy_1, done_1;
    logic [3:0] in_data_1;
    logic       in_valid_3, in_ready_3, d_3, s0_3, s1_3, dv_3, busy_3, done_3;
    logic [3:0] in_data_3;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] EXP_IDLE  = 7'b1000000;
    localparam logic [6:0] EXP_DONE  = 7'b0100001;
    localparam logic [6:0] EXP_RESET = 7'b0000000;

    demux_seq #(.HOLD_CYCLES(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .in_data(in_data_1), .d(d_1), .s0(s0_1), .s1(s1_1), .dv(dv_1),
        .busy(busy_1), .done(done_1)
    );

    demux_seq #(.HOLD_CYCLES(3)) dut_3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_3), .in_ready(in_ready_3),
        .in_data(in_data_3), .d(d_3), .s0(s0_3), .s1(s1_3), .dv(dv_3),
        .busy(busy_3), .done(done_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector {in_ready, busy, dv, d, s0, s1, done}
    function automatic logic [6:0] obs(input logic use3);
        if (use3) return {in_ready_3, busy_3, dv_3, d_3, s0_3, s1_3, done_3};
        return {in_ready_1, busy_1, dv_1, d_1, s0_1, s1_1, done_1};
    endfunction

    function automatic logic [6:0] exp_drive(input logic bit_v, input int ch);
        logic [1:0] c;
        c = 2'(ch);
        return {1'b0, 1'b1, 1'b1, bit_v, c[1], c[0], 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // From the negedge showing the first post-accept cycle: check every drive cycle, then done.
    task automatic check_body(input logic [3:0] w, input int hold, input logic use3, input string tag);
        logic [3:0] mask;
`ifdef DEMUX_SEQ_SKIP_ZERO_EN
        mask = w;
`else
        mask = 4'hF;
`endif
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                for (int h = 0; h < hold; h++) begin
                    check($sformatf("%s ch%0d h%0d", tag, k, h), {25'd0, obs(use3)}, {25'd0, exp_drive(w[k], k)});
                    @(negedge clk);
                end
            end
        end
        check($sformatf("%s done", tag), {25'd0, obs(use3)}, {25'd0, EXP_DONE});
    endtask

    // Called at a negedge with the target idle; corrupts in_data while busy to prove it is ignored.
    task automatic send_word(input logic [3:0] w, input int hold, input logic use3, input string tag);
        if (use3) begin in_valid_3 = 1'b1; in_data_3 = w; end
        else      begin in_valid_1 = 1'b1; in_data_1 = w; end
        @(negedge clk);
        if (use3) begin in_valid_3 = 1'b0; in_data_3 = ~w; end
        else      begin in_valid_1 = 1'b0; in_data_1 = ~w; end
        check_body(w, hold, use3, tag);
        @(negedge clk);
        check($sformatf("%s idle", tag), {25'd0, obs(use3)}, {25'd0, EXP_IDLE});
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid_1 = 1'b0; in_data_1 = 4'h0;
        in_valid_3 = 1'b0; in_data_3 = 4'h0;

        #1;
        check("reset outs 1", {25'd0, obs(1'b0)}, {25'd0, EXP_RESET});
        check("reset outs 3", {25'd0, obs(1'b1)}, {25'd0, EXP_RESET});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post reset idle 1", {25'd0, obs(1'b0)}, {25'd0, EXP_IDLE});
        check("post reset idle 3", {25'd0, obs(1'b1)}, {25'd0, EXP_IDLE});

        // Basic word, HOLD=1
        send_word(4'b1010, 1, 1'b0, "w1010");

        // HOLD=3 all ones: 12 drive cycles plus done, in_ready low throughout
        send_word(4'b1111, 3, 1'b1, "h3w1111");

        // Zero-skip pattern and all-zero word
        send_word(4'b0100, 1, 1'b0, "w0100");
        send_word(4'b0000, 1, 1'b0, "w0000");
        send_word(4'b0000, 3, 1'b1, "h3w0000");

        // in_valid held continuously: second word taken after one IDLE cycle
        in_valid_1 = 1'b1; in_data_1 = 4'h5;
        @(negedge clk);
        in_data_1 = 4'hA;
        check_body(4'h5, 1, 1'b0, "b2b w5");
        @(negedge clk);
        check("b2b gap idle", {25'd0, obs(1'b0)}, {25'd0, EXP_IDLE});
        @(negedge clk);
        in_valid_1 = 1'b0;
        check_body(4'hA, 1, 1'b0, "b2b wA");
        @(negedge clk);
        check("b2b end idle", {25'd0, obs(1'b0)}, {25'd0, EXP_IDLE});

        // Asynchronous reset during ch2 of 4'hF
        in_valid_1 = 1'b1; in_data_1 = 4'hF;
        @(negedge clk);
        in_valid_1 = 1'b0;
        check("rst ch0", {25'd0, obs(1'b0)}, {25'd0, exp_drive(1'b1, 0)});
        @(negedge clk);
        @(negedge clk);
        check("rst ch2", {25'd0, obs(1'b0)}, {25'd0, exp_drive(1'b1, 2)});
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async outs", {25'd0, obs(1'b0)}, {25'd0, EXP_RESET});
        repeat (2) @(negedge clk);
        check("rst held no done", {25'd0, obs(1'b0)}, {25'd0, EXP_RESET});
        rst_n = 1'b1;
        #1;
        check("rst release idle", {25'd0, obs(1'b0)}, {25'd0, EXP_IDLE});
        @(negedge clk);
        check("rst no late done", {25'd0, obs(1'b0)}, {25'd0, EXP_IDLE});
        send_word(4'b0011, 1, 1'b0, "after rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/demux_seq.md
DEMUX_SEQ -- requirements
Module: demux_seq

Interface
REQ-001 The block SHALL be an upstream sequencer that serializes a 4-bit word onto the d/s0/s1 inputs of a 1-to-4 demux, one channel at a time.
REQ-002 Parameter: HOLD_CYCLES, default 1, cycles each channel is driven (legal 1..16).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 in_data  input  4  word; bit k goes to demux channel k.
REQ-008 d  output  1  serialized data bit to the demux.
REQ-009 s0  output  1  channel select MSB.
REQ-010 s1  output  1  channel select LSB.
REQ-011 dv  output  1  d/s0/s1 carry a live channel this cycle.
REQ-012 busy  output  1  word in progress.
REQ-013 done  output  1  one-cycle pulse after the last channel of a word.

Function
REQ-014 Channel k SHALL be encoded {s0,s1}=k: ch0=00 (y1), ch1=01 (y2), ch2=10 (y3), ch3=11 (y4).
REQ-015 FSM states SHALL be IDLE, DRIVE, DONE; all outputs registered.
REQ-016 IDLE: in_ready=1, busy=0, dv=0, d=0, s0=s1=0, done=0.
REQ-017 Accept on in_valid&&in_ready at edge N; in_data latched at N; DRIVE ch0 visible after edge N.
REQ-018 DRIVE: in_ready=0, busy=1, dv=1, d=latched bit[k], {s0,s1}=k, held exactly HOLD_CYCLES cycles per channel.
REQ-019 Hold counter SHALL load HOLD_CYCLES-1 on channel entry, decrement each cycle, advance channel at 0.
REQ-020 Channel order SHALL be ascending ch0..ch3; after ch3 expires, go to DONE.
REQ-021 DONE: one cycle, done=1, busy=1, dv=0, d=0, s0=s1=0, in_ready=0; then IDLE.
REQ-022 Word period SHALL be 4*HOLD_CYCLES+1 cycles busy; next accept earliest the cycle after DONE (throughput 4*HOLD_CYCLES+2).
REQ-023 in_valid and in_data while in_ready=0 SHALL be ignored; a held in_valid is accepted on return to IDLE.
REQ-024 d SHALL never change without dv=1 or s0/s1 being 00; no select glitch within a channel hold.

Reset
REQ-025 rst_n low SHALL immediately force IDLE outputs (in_ready=1 is not asserted until rst_n deasserts; during reset in_ready=0), channel=0, counter=0, latched word=0.
REQ-026 Reset mid-DRIVE or mid-DONE SHALL discard the word; no done pulse is produced.
REQ-027 Reset deassertion SHALL be treated synchronously to clk; first accept possible at the first edge with rst_n high.

Configuration
REQ-028 Macro DEMUX_SEQ_SKIP_ZERO_EN: when defined, channels whose latched bit is 0 SHALL be skipped (no DRIVE cycles); an all-zero word SHALL go from accept directly to DONE.
REQ-029 Without DEMUX_SEQ_SKIP_ZERO_EN, all four channels SHALL be driven regardless of data.

Structure
REQ-030 Package demux_seq_pkg SHALL hold the state enum, the 2-bit channel index type, HOLD counter width (4) and the channel-to-{s0,s1} encoding.
REQ-031 Sub-module demux_seq_hold_ctr SHALL implement the loadable down-counter with zero flag.

Verification
REQ-032 HOLD=1, in_data=4'b1010 -> d=0,1,0,1 with {s0,s1}=00,01,10,11 over 4 cycles, done pulse on cycle 5.
REQ-033 HOLD=3, in_data=4'b1111 -> each channel held 3 cycles, busy 13 cycles, in_ready low throughout.
REQ-034 in_valid held high continuously, two words 4'h5 then 4'hA -> second accepted the cycle after done; gap of exactly one IDLE cycle.
REQ-035 rst_n low during ch2 of 4'hF -> outputs to reset values without clock edge; no done; new word after reset starts at ch0.
REQ-036 DEMUX_SEQ_SKIP_ZERO_EN, in_data=4'b0100 -> only ch2 driven (s0=1,s1=0,d=1); in_data=4'b0000 -> done the cycle after accept.
